// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller, its datapath and the bench.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExec     = 4'd6,
    StRWb      = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9,
    StAddiExec = 4'd10,
    StAddiWb   = 4'd11
  } mc_state_e;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  localparam logic [1:0] AluBReg    = 2'b00;
  localparam logic [1:0] AluBFour   = 2'b01;
  localparam logic [1:0] AluBImm    = 2'b10;
  localparam logic [1:0] AluBImmSh  = 2'b11;

endpackage

// File: rtl/multi_cycle_ctr.sv
// Multi-cycle MIPS-style control FSM: registered state, control outputs decoded
// from the current state plus memReady/opCode so handshakes take effect the same cycle.
module multi_cycle_ctr
  import mc_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opCode,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       memToReg,
  output logic       irWrite,
  output logic       aluSrcA,
  output logic       regWrite,
  output logic       regDst,
  output logic [1:0] pcSource,
  output logic [1:0] aluOp,
  output logic [1:0] aluSrcB,
  output logic       instrDone,
  output logic       illegalOp,
  output logic [3:0] state
);

  mc_state_e state_q, state_d;
  logic      mem_rdy;
  logic      last_cyc;

  assign mem_rdy = MEM_WAIT_EN ? memReady : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = StFetch;
    last_cyc    = 1'b0;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    memToReg    = 1'b0;
    irWrite     = 1'b0;
    aluSrcA     = 1'b0;
    regWrite    = 1'b0;
    regDst      = 1'b0;
    pcSource    = PcSrcAlu;
    aluOp       = AluOpAdd;
    aluSrcB     = AluBReg;
    illegalOp   = 1'b0;

    case (state_q)
      StFetch: begin
        memRead = 1'b1;
        aluSrcB = AluBFour;
        if (mem_rdy) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          state_d = StDecode;
        end else begin
          state_d = StFetch;
        end
      end
      StDecode: begin
        aluSrcB = AluBImmSh;
        case (opCode)
          OpLw, OpSw: state_d = StMemAddr;
          OpRType:    state_d = StExec;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
          OpAddi:     state_d = StAddiExec;
          default: begin
            illegalOp = 1'b1;
            state_d   = StFetch;
          end
        endcase
      end
      StMemAddr: begin
        aluSrcA = 1'b1;
        aluSrcB = AluBImm;
        state_d = (opCode == OpLw) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        memRead = 1'b1;
        iorD    = 1'b1;
        state_d = mem_rdy ? StMemWb : StMemRead;
      end
      StMemWb: begin
        regWrite = 1'b1;
        memToReg = 1'b1;
        last_cyc = 1'b1;
      end
      StMemWrite: begin
        iorD     = 1'b1;
        memWrite = 1'b1;
        last_cyc = mem_rdy;
        state_d  = mem_rdy ? StFetch : StMemWrite;
      end
      StExec: begin
        aluSrcA = 1'b1;
        aluOp   = AluOpFunct;
        state_d = StRWb;
      end
      StRWb: begin
        regWrite = 1'b1;
        regDst   = 1'b1;
        last_cyc = 1'b1;
      end
      StBranch: begin
        aluSrcA     = 1'b1;
        aluOp       = AluOpSub;
        pcWriteCond = 1'b1;
        pcSource    = PcSrcAluOut;
        last_cyc    = 1'b1;
      end
      StJump: begin
        pcWrite  = 1'b1;
        pcSource = PcSrcJump;
        last_cyc = 1'b1;
      end
      StAddiExec: begin
        aluSrcA = 1'b1;
        aluSrcB = AluBImm;
        state_d = StAddiWb;
      end
      StAddiWb: begin
        regWrite = 1'b1;
        last_cyc = 1'b1;
      end
      default: state_d = StFetch;
    endcase

    instrDone = last_cyc;

    // Reset forces every output low immediately so an abandoned access never writes.
    if (reset) begin
      pcWrite     = 1'b0;
      pcWriteCond = 1'b0;
      iorD        = 1'b0;
      memRead     = 1'b0;
      memWrite    = 1'b0;
      memToReg    = 1'b0;
      irWrite     = 1'b0;
      aluSrcA     = 1'b0;
      regWrite    = 1'b0;
      regDst      = 1'b0;
      pcSource    = 2'b00;
      aluOp       = 2'b00;
      aluSrcB     = 2'b00;
      instrDone   = 1'b0;
      illegalOp   = 1'b0;
    end
  end

  assign state = reset ? 4'd0 : state_q;

endmodule

// File: doc/multi_cycle_ctr.md
MULTI_CYCLE_CTR -- requirements
Module: multi_cycle_ctr

Interface
REQ-001 Parameter: MEM_WAIT_EN, default 1, meaning: 1 = honour memReady; 0 = treat memReady as constant 1.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  reset; synchronous and active-high.
REQ-004 opCode  input  6  instruction bits [31:26] from the instruction register.
REQ-005 memReady  input  1  memory completes the current read or write this cycle.
REQ-006 pcWrite, pcWriteCond, iorD, memRead, memWrite, memToReg, irWrite, aluSrcA, regWrite, regDst  output  1 each  standard multi-cycle datapath controls.
REQ-007 pcSource  output  2  PC mux select: 00 = ALU, 01 = ALUOut, 10 = jump target.
REQ-008 aluOp  output  2  drives the ALU control decoder: 00 = add, 01 = subtract, 10 = decode funct.
REQ-009 aluSrcB  output  2  ALU B select: 00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate.
REQ-010 instrDone  output  1  one-cycle pulse on the last cycle of each instruction.
REQ-011 illegalOp  output  1  one-cycle pulse in DECODE when opCode is unsupported.
REQ-012 state  output  4  current state encoding, for debug.

Function
REQ-013 The FSM SHALL have 12 states, encoded 0..11 in this order: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC, R_WB, BRANCH, JUMP, ADDI_EXEC, ADDI_WB.
REQ-014 FETCH SHALL drive memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00; irWrite and pcWrite SHALL be 1 only when memReady=1.
REQ-015 FETCH SHALL stay in FETCH while memReady=0 and go to DECODE when memReady=1.
REQ-016 DECODE SHALL drive aluSrcA=0, aluSrcB=11, aluOp=00.
REQ-017 DECODE next state by opCode: 100011 or 101011 -> MEM_ADDR; 000000 -> EXEC; 000100 -> BRANCH; 000010 -> JUMP; 001000 -> ADDI_EXEC; any other value -> FETCH with illegalOp=1.
REQ-018 MEM_ADDR SHALL drive aluSrcA=1, aluSrcB=10, aluOp=00; it SHALL go to MEM_READ if opCode=100011, otherwise to MEM_WRITE.
REQ-019 MEM_READ SHALL drive memRead=1, iorD=1; it SHALL hold until memReady=1, then go to MEM_WB.
REQ-020 MEM_WB SHALL drive regWrite=1, memToReg=1, regDst=0, then go to FETCH.
REQ-021 MEM_WRITE SHALL drive iorD=1 with memWrite=1 in every cycle it occupies; it SHALL go to FETCH on memReady=1.
REQ-022 EXEC SHALL drive aluSrcA=1, aluSrcB=00, aluOp=10, then go to R_WB. R_WB SHALL drive regWrite=1, regDst=1, memToReg=0, then go to FETCH.
REQ-023 BRANCH SHALL drive aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01, then go to FETCH.
REQ-024 JUMP SHALL drive pcWrite=1, pcSource=10, then go to FETCH.
REQ-025 ADDI_EXEC SHALL drive aluSrcA=1, aluSrcB=10, aluOp=00, then go to ADDI_WB. ADDI_WB SHALL drive regWrite=1, regDst=0, memToReg=0, then go to FETCH.
REQ-026 Any output not listed for a state SHALL be 0 in that state.
REQ-027 instrDone SHALL be 1 on every cycle whose next state is FETCH, except the illegal-opcode cycle and FETCH self-loops.
REQ-028 With zero wait states, instruction latencies SHALL be: lw 5 cycles; sw, R-type, addi 4; beq, j 3.
REQ-029 Unused state encodings 12..15 SHALL go to FETCH with all outputs 0.
REQ-030 memReady SHALL be ignored in every state except FETCH, MEM_READ and MEM_WRITE.

Reset
REQ-031 While reset=1, all outputs SHALL be 0 and state SHALL load FETCH on the clock edge.
REQ-032 A reset asserted mid-instruction, including during a wait state, SHALL abandon the instruction with no write-enable pulse.
REQ-033 In the first cycle after reset deasserts, the block SHALL be in FETCH.

Structure
REQ-034 State encodings, opcode constants and aluOp codes SHALL live in shared package mc_ctrl_pkg, also used by the datapath and the bench.
REQ-035 The block SHALL be a single module with no sub-module; the ALU control decoder SHALL be instantiated in the datapath, not here.

Verification
REQ-036 Reset held 3 cycles, then released -> state=0, all write enables 0 during reset; memRead=1 on the first cycle after release.
REQ-037 opCode=000000, memReady=1 -> states 0,1,6,7,0; aluOp=10 in EXEC; regWrite=1, regDst=1 in R_WB; instrDone pulses once.
REQ-038 opCode=100011, memReady low for 2 cycles in MEM_READ -> states 0,1,2,3,3,3,4,0; 7 cycles total; memToReg=1 only in MEM_WB.
REQ-039 opCode=000100 -> BRANCH with aluOp=01, pcWriteCond=1, pcSource=01; 3 cycles total.
REQ-040 opCode=111111 -> illegalOp=1 in DECODE, next state FETCH, instrDone stays 0.
REQ-041 opCode=101011 with reset asserted in MEM_WRITE while memReady=0 -> memWrite=0 from the reset cycle on; state=FETCH after the edge.
